// File: rtl/hexdef_ctrl_pkg.sv
// Shared constants, FSM state type and a small index helper for the
// four-player buzzer input arbiter.
package hexdef_ctrl_pkg;

    localparam int NUM_PLAYERS     = 4;
    localparam int SW_WIDTH        = 8;
    localparam int PINS_PER_PLAYER = 9;
    localparam int PIN_WIDTH       = NUM_PLAYERS * PINS_PER_PLAYER;
    localparam int PLAYER_W        = $clog2(NUM_PLAYERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Player index reached by stepping 'offset' positions from 'base';
    // the index width makes the wrap-around modulo NUM_PLAYERS implicit.
    function automatic logic [PLAYER_W-1:0] rr_index(
        input logic [PLAYER_W-1:0] base,
        input logic [PLAYER_W-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/player_input_arbiter_btn_debounce.sv
// One button: two-flop synchronizer followed by a stability counter.
// The debounced level follows the synchronized level only after the two
// have disagreed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             db_reg;

    // Synchronize the raw pin, then count consecutive disagreeing cycles;
    // any agreement restarts the count, and the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
            cnt_reg  <= '0;
            db_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
            if (sync_reg[1] != db_reg) begin
                if (cnt_reg >= CNT_LAST) begin
                    db_reg  <= sync_reg[1];
                    cnt_reg <= '0;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign db = db_reg;

endmodule

// File: rtl/player_input_arbiter.sv
// Four-player answer arbiter: synchronizes switches, debounces buttons,
// grants the first press of an open round with round-robin tie-breaking,
// holds the answer until acknowledged and waits for all buttons to clear.
module player_input_arbiter
    import hexdef_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PIN_WIDTH-1:0] gpins,
    input  logic                 round_open,
    input  logic                 ack,
    output logic                 answer_valid,
    output logic [PLAYER_W-1:0]  answer_player,
    output logic [SW_WIDTH-1:0]  answer_value,
    output logic [NUM_PLAYERS-1:0] btn_db
);

    logic [SW_WIDTH-1:0]    sw_sync [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] btn_db_prev_reg;
    logic [NUM_PLAYERS-1:0] press;

    arb_state_t             state_reg;
    logic [PLAYER_W-1:0]    rr_ptr_reg;
    logic                   answer_valid_reg;
    logic [PLAYER_W-1:0]    answer_player_reg;
    logic [SW_WIDTH-1:0]    answer_value_reg;

    logic                   win_found;
    logic [PLAYER_W-1:0]    win_idx;
    logic [PLAYER_W-1:0]    cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [SW_WIDTH-1:0] sw_meta_reg;
            logic [SW_WIDTH-1:0] sw_sync_reg;

            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (gpins[gi*PINS_PER_PLAYER + SW_WIDTH]),
                .db    (btn_db[gi])
            );

            // Two-flop synchronizer for this player's answer switches.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sw_meta_reg <= '0;
                    sw_sync_reg <= '0;
                end else begin
                    sw_meta_reg <= gpins[gi*PINS_PER_PLAYER +: SW_WIDTH];
                    sw_sync_reg <= sw_meta_reg;
                end
            end

            assign sw_sync[gi] = sw_sync_reg;
        end
    endgenerate

    // Previous debounced levels, used to turn a rising edge into a press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db_prev_reg <= '0;
        end else begin
            btn_db_prev_reg <= btn_db;
        end
    end

    assign press = btn_db & ~btn_db_prev_reg;

    // Pick the first pressing player at or after the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_reg;
        cand      = rr_ptr_reg;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            cand = rr_index(rr_ptr_reg, PLAYER_W'(k));
            if (!win_found && press[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbitration FSM with registered answer outputs and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= '0;
            answer_valid_reg  <= 1'b0;
            answer_player_reg <= '0;
            answer_value_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (round_open && (btn_db == '0)) begin
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    // Closing the round wins over a press in the same cycle.
                    if (!round_open) begin
                        state_reg <= IDLE;
                    end else if (win_found) begin
                        answer_player_reg <= win_idx;
                        answer_value_reg  <= sw_sync[win_idx];
                        answer_valid_reg  <= 1'b1;
                        rr_ptr_reg        <= win_idx + 1'b1;
                        state_reg         <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        answer_valid_reg <= 1'b0;
                        state_reg        <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (btn_db == '0) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign answer_valid  = answer_valid_reg;
    assign answer_player = answer_player_reg;
    assign answer_value  = answer_value_reg;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Randomized and directed bench for player_input_arbiter with a short
// debounce window, compared cycle by cycle against a behavioural model.
module tb_player_input_arbiter;

    localparam int D = 4;
    localparam int S_IDLE = 0, S_ARMED = 1, S_GRANT = 2, S_RELEASE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] gp;
    logic        ro;
    logic        ak;
    logic        answer_valid;
    logic [1:0]  answer_player;
    logic [7:0]  answer_value;
    logic [3:0]  btn_db;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state.
    logic [35:0]  m_s1, m_s2;
    logic [3:0]   m_db, m_dbp;
    logic [D-1:0] m_hist [4];
    int           m_state, m_rr;
    logic         m_valid;
    logic [1:0]   m_ply;
    logic [7:0]   m_val;

    always #5 clk = ~clk;

    player_input_arbiter #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gpins         (gp),
        .round_open    (ro),
        .ack           (ak),
        .answer_valid  (answer_valid),
        .answer_player (answer_player),
        .answer_value  (answer_value),
        .btn_db        (btn_db)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
        for (int p = 0; p < 4; p++) m_hist[p] = '0;
        m_state = S_IDLE; m_rr = 0; m_valid = 1'b0; m_ply = '0; m_val = '0;
    endtask

    // Apply one rising edge to the model using the inputs held before it.
    task automatic model_edge();
        logic [3:0] press, db_new;
        int w;
        press = m_db & ~m_dbp;
        case (m_state)
            S_IDLE:    if (ro && m_db == 4'd0) m_state = S_ARMED;
            S_ARMED: begin
                if (!ro) begin
                    m_state = S_IDLE;
                end else if (press != 4'd0) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && press[(m_rr + k) % 4]) w = (m_rr + k) % 4;
                    m_ply   = w[1:0];
                    m_val   = m_s2[9*w +: 8];
                    m_valid = 1'b1;
                    m_rr    = (w + 1) % 4;
                    m_state = S_GRANT;
                    $display("cycle %0d: grant player %0d value 0x%0h", cyc, w, m_val);
                end
            end
            S_GRANT:   if (ak) begin m_valid = 1'b0; m_state = S_RELEASE; end
            default:   if (m_db == 4'd0) m_state = S_IDLE;
        endcase
        // A button flips once its last D synchronized samples all disagree.
        for (int p = 0; p < 4; p++) begin
            m_hist[p] = {m_hist[p][D-2:0], m_s2[9*p+8]};
            db_new[p] = (m_hist[p] == {D{~m_db[p]}}) ? ~m_db[p] : m_db[p];
        end
        m_dbp = m_db;
        m_db  = db_new;
        m_s2  = m_s1;
        m_s1  = gp;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        cyc++;
        #1;
        check("valid",  answer_valid,  m_valid);
        check("player", answer_player, m_ply);
        check("value",  answer_value,  m_val);
        check("btn_db", btn_db,        m_db);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input int p, input logic v);
        gp[9*p+8] = v;
    endtask

    task automatic set_sw(input int p, input logic [7:0] v);
        gp[9*p +: 8] = v;
    endtask

    task automatic pulse_ack();
        ak = 1'b1;
        step();
        ak = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!answer_valid && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_valid",  answer_valid,  1'b0);
        check("rst_player", answer_player, 2'd0);
        check("rst_value",  answer_value,  8'd0);
        check("rst_btn_db", btn_db,        4'd0);
        @(posedge clk);
        #1;
        check("rst_hold_valid",  answer_valid, 1'b0);
        check("rst_hold_btn_db", btn_db,       4'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] seen_db;
        logic       seen_v;
        logic       b;
        logic [3:0] tgt;

        gp = '0; ro = 1'b0; ak = 1'b0; rst_n = 1'b0;
        do_reset();

        // Single press by player 2 with sw = 0xA5.
        ro = 1'b1;
        steps(3);
        set_sw(2, 8'hA5);
        set_btn(2, 1'b1);
        wait_valid(20, n);
        check("s1_latency", n, D + 3);
        check("s1_player", answer_player, 2'd2);
        check("s1_value",  answer_value,  8'hA5);
        set_sw(2, 8'h3C);
        steps(5);
        check("s1_hold_value", answer_value, 8'hA5);
        pulse_ack();
        check("s1_ack_valid", answer_valid, 1'b0);
        steps(4);
        set_btn(2, 1'b0);
        steps(12);
        pulse_ack();

        // Simultaneous press by players 1 and 3, twice.
        gp = '0;
        do_reset();
        ro = 1'b1;
        steps(3);
        set_btn(1, 1'b1); set_btn(3, 1'b1);
        wait_valid(20, n);
        check("s2_first_player", answer_player, 2'd1);
        pulse_ack();
        set_btn(1, 1'b0); set_btn(3, 1'b0);
        steps(12);
        set_btn(1, 1'b1); set_btn(3, 1'b1);
        wait_valid(20, n);
        check("s2_second_player", answer_player, 2'd3);
        pulse_ack();
        set_btn(1, 1'b0); set_btn(3, 1'b0);
        steps(12);

        // Bounce: toggle every 2 cycles for 20 cycles.
        seen_db = '0; seen_v = 1'b0; b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) b = ~b;
            set_btn(0, b);
            step();
            seen_db |= btn_db; seen_v |= answer_valid;
        end
        set_btn(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            seen_db |= btn_db; seen_v |= answer_valid;
        end
        check("s3_btn_db", seen_db, 4'd0);
        check("s3_valid",  seen_v,  1'b0);

        // Lockout: player 1 presses during grant, player 0 still held after ack.
        set_sw(0, 8'h5A);
        set_btn(0, 1'b1);
        wait_valid(20, n);
        check("s4_player", answer_player, 2'd0);
        set_btn(1, 1'b1);
        steps(8);
        check("s4_hold_player", answer_player, 2'd0);
        check("s4_hold_valid",  answer_valid,  1'b1);
        pulse_ack();
        seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); seen_v |= answer_valid; end
        set_btn(0, 1'b0);
        for (int i = 0; i < 10; i++) begin step(); seen_v |= answer_valid; end
        check("s4_no_second_grant", seen_v, 1'b0);
        set_btn(1, 1'b0);
        steps(12);

        // Round closes on the same cycle as the press event.
        set_btn(2, 1'b1);
        steps(D + 2);
        check("s5_press_cycle_db", btn_db[2], 1'b1);
        ro = 1'b0;
        seen_v = 1'b0;
        for (int i = 0; i < 10; i++) begin step(); seen_v |= answer_valid; end
        check("s5_valid", seen_v, 1'b0);
        set_btn(2, 1'b0);
        steps(12);

        // Reset mid-grant, then a fresh round starts from pointer 0.
        ro = 1'b1;
        steps(3);
        set_sw(1, 8'h77);
        set_btn(1, 1'b1);
        wait_valid(20, n);
        check("s6_player", answer_player, 2'd1);
        gp = '0;
        do_reset();
        ro = 1'b1;
        steps(3);
        set_btn(0, 1'b1); set_btn(2, 1'b1);
        wait_valid(20, n);
        check("s6_after_reset_player", answer_player, 2'd0);
        pulse_ack();
        gp = '0;
        steps(12);

        // Randomized traffic.
        do_reset();
        tgt = '0;
        ro  = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) ro = ~ro;
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 11) == 0) tgt[p] = ~tgt[p];
                set_btn(p, tgt[p] ^ ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 9) == 0) set_sw(p, 8'($urandom));
            end
            ak = ($urandom_range(0, 7) == 0);
            step();
        end
        ak = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
